// File: rtl/processor_pkg.sv
// Shared encodings for the multicycle processor: opcodes, ALU operations,
// controller state encodings and the decoded-instruction control word.
package processor_pkg;

  // Primary opcodes, Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Controller states; the encoding is visible on the State debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Instruction class as seen by the sequencer
  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_LW,
    CLS_SW,
    CLS_B,
    CLS_BEQ,
    CLS_BNE,
    CLS_ILLEGAL
  } instr_cls_t;

  // Decoded control word, latched once per instruction in DECODE
  typedef struct packed {
    instr_cls_t cls;
    logic [3:0] alu_func;
    logic       alu_bin_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{cls: CLS_ILLEGAL, alu_func: ALU_ADD, alu_bin_sel: 1'b0};

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/func decode: instruction class plus the ALU controls
// used in EXEC.
module control_decode
  import processor_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [3:0] i_func,
  output ctrl_t      o_ctrl
);

  // Classify the opcode and select the EXEC-phase ALU operation and B input
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves o_ctrl unassigned (no latch).
    o_ctrl = '{cls: CLS_ILLEGAL, alu_func: ALU_ADD, alu_bin_sel: 1'b1};
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.cls         = CLS_RTYPE;
        o_ctrl.alu_func    = i_func;
        o_ctrl.alu_bin_sel = 1'b0;
      end
      OP_LI, OP_ADDI: o_ctrl.cls = CLS_IMM;
      OP_ANDI: begin
        o_ctrl.cls      = CLS_IMM;
        o_ctrl.alu_func = ALU_AND;
      end
      OP_ORI: begin
        o_ctrl.cls      = CLS_IMM;
        o_ctrl.alu_func = ALU_OR;
      end
      OP_LW:   o_ctrl.cls = CLS_LW;
      OP_SW:   o_ctrl.cls = CLS_SW;
      OP_B:    o_ctrl.cls = CLS_B;
      OP_BEQ:  o_ctrl.cls = CLS_BEQ;
      OP_BNE:  o_ctrl.cls = CLS_BNE;
      default: o_ctrl.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor controller: FETCH/DECODE/EXEC/MEM/WB/BRANCH sequencer
// with a bounded data-memory wait and a sticky illegal/timeout error state.
module multicycle_control
  import processor_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15  // must be >= 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MEM_Ack,
  output logic        IR_LdEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic        MEM_WrEn,
  output logic [3:0]  ALU_func,
  output logic        MEM_Req,
  output logic        Illegal,
  output logic [2:0]  State
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_next;
  ctrl_t             w_ctrl;
  ctrl_t             r_ctrl;
  logic [WAIT_W-1:0] r_wait;
  logic              r_illegal;
  logic              w_unused_instr;

  // Only the opcode and func fields drive control
  assign w_unused_instr = ^Instr[25:4];

  control_decode u_decode (
    .i_opcode (Instr[31:26]),
    .i_func   (Instr[3:0]),
    .o_ctrl   (w_ctrl)
  );

  // State register, per-instruction control latch, MEM wait counter, sticky error
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register here samples pre-edge values.
    if (!Reset) begin
      r_state   <= ST_FETCH;
      r_ctrl    <= CTRL_NOP;
      r_wait    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) r_ctrl <= w_ctrl;
      if (w_state_next == ST_ERR) r_illegal <= 1'b1;
      // Counter is held at zero outside MEM, so it is clear on every MEM entry
      if (r_state != ST_MEM)      r_wait <= '0;
      else if (r_wait != WAIT_MAX) r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Next-state sequencing
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        case (w_ctrl.cls)
          CLS_RTYPE, CLS_IMM, CLS_LW, CLS_SW: w_state_next = ST_EXEC;
          CLS_B, CLS_BEQ, CLS_BNE:            w_state_next = ST_BRANCH;
          default:                            w_state_next = ST_ERR;
        endcase
      end
      ST_EXEC: begin
        if (r_ctrl.cls == CLS_LW || r_ctrl.cls == CLS_SW) w_state_next = ST_MEM;
        else                                              w_state_next = ST_WB;
      end
      ST_MEM: begin
        // Acknowledge wins over timeout in the final allowed cycle
        if (MEM_Ack)                 w_state_next = (r_ctrl.cls == CLS_SW) ? ST_FETCH : ST_WB;
        else if (r_wait >= WAIT_LAST) w_state_next = ST_ERR;
      end
      ST_WB, ST_BRANCH: w_state_next = ST_FETCH;
      ST_ERR:           w_state_next = ST_ERR;
      default:          w_state_next = ST_ERR;
    endcase
  end

  // Output decode from state and latched control; everything is forced low while Reset is held
  always_comb begin
    IR_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    MEM_WrEn      = 1'b0;
    MEM_Req       = 1'b0;
    ALU_func      = ALU_ADD;
    if (Reset) begin
      case (r_state)
        ST_FETCH: IR_LdEn = 1'b1;
        ST_EXEC: begin
          ALU_func    = r_ctrl.alu_func;
          ALU_Bin_sel = r_ctrl.alu_bin_sel;
        end
        ST_MEM: begin
          MEM_Req  = 1'b1;
          MEM_WrEn = (r_ctrl.cls == CLS_SW);
          PC_LdEn  = (r_ctrl.cls == CLS_SW) && MEM_Ack;
        end
        ST_WB: begin
          RF_WrEn       = 1'b1;
          PC_LdEn       = 1'b1;
          RF_WrData_sel = (r_ctrl.cls == CLS_LW);
        end
        ST_BRANCH: begin
          ALU_func = ALU_SUB;
          RF_B_sel = 1'b1;
          PC_LdEn  = 1'b1;
          case (r_ctrl.cls)
            CLS_B:   PC_sel = 1'b1;
            CLS_BEQ: PC_sel = Zero;
            CLS_BNE: PC_sel = ~Zero;
            default: PC_sel = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Illegal = r_illegal;
  assign State   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle input rows with
// hand-computed output vectors, one task per scenario.
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic        MEM_Ack = 1'b0;
  logic        IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic        ALU_Bin_sel, MEM_WrEn, MEM_Req, Illegal;
  logic [3:0]  ALU_func;
  logic [2:0]  State;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .Zero          (Zero),
    .MEM_Ack       (MEM_Ack),
    .IR_LdEn       (IR_LdEn),
    .PC_sel        (PC_sel),
    .PC_LdEn       (PC_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .MEM_WrEn      (MEM_WrEn),
    .ALU_func      (ALU_func),
    .MEM_Req       (MEM_Req),
    .Illegal       (Illegal),
    .State         (State)
  );

  always #5 Clk = ~Clk;

  // Observed vector: State, IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel,
  // RF_B_sel, ALU_Bin_sel, MEM_WrEn, MEM_Req, Illegal, ALU_func
  logic [16:0] w_obs;
  assign w_obs = {State, IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel,
                  RF_B_sel, ALU_Bin_sel, MEM_WrEn, MEM_Req, Illegal, ALU_func};

  typedef struct {
    logic [31:0] instr;
    logic        ack;
    logic        zero;
    logic        rst;
    logic [16:0] exp;
  } row_t;

  localparam logic [31:0] I_SUB  = 32'h8000_0001;
  localparam logic [31:0] I_RF7  = 32'h8000_00F7;
  localparam logic [31:0] I_ANDI = 32'hC800_0000;
  localparam logic [31:0] I_ORI  = 32'hCC00_0000;
  localparam logic [31:0] I_LI   = 32'hE000_0000;
  localparam logic [31:0] I_LW   = 32'h3C00_0000;
  localparam logic [31:0] I_SW   = 32'h7C00_0000;
  localparam logic [31:0] I_BEQ  = 32'h0000_0000;
  localparam logic [31:0] I_BNE  = 32'h0400_0000;
  localparam logic [31:0] I_B    = 32'hFC00_0000;
  localparam logic [31:0] I_BAD  = 32'h5400_0000;

  function automatic logic [16:0] ev(input int st, input logic ir, pcsel, pcld, rfwr,
                                     wdsel, bsel, binsel, memwr, memreq, ill,
                                     input logic [3:0] alu);
    return {3'(st), ir, pcsel, pcld, rfwr, wdsel, bsel, binsel, memwr, memreq, ill, alu};
  endfunction

  function automatic logic [16:0] e_fetch();
    return ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
  endfunction
  function automatic logic [16:0] e_decode();
    return ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [3:0] alu, input logic binsel);
    return ev(2, 0, 0, 0, 0, 0, 0, binsel, 0, 0, 0, alu);
  endfunction
  function automatic logic [16:0] e_mem(input logic wr, input logic pcld);
    return ev(3, 0, 0, pcld, 0, 0, 0, 0, wr, 1, 0, 4'h0);
  endfunction
  function automatic logic [16:0] e_wb(input logic wdsel);
    return ev(4, 0, 0, 1, 1, wdsel, 0, 0, 0, 0, 0, 4'h0);
  endfunction
  function automatic logic [16:0] e_br(input logic pcsel);
    return ev(5, 0, pcsel, 1, 0, 0, 1, 0, 0, 0, 0, 4'h1);
  endfunction
  function automatic logic [16:0] e_err();
    return ev(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0);
  endfunction
  function automatic logic [16:0] e_quiet(input int st, input logic ill);
    return ev(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill, 4'h0);
  endfunction

  function automatic row_t mk(input logic [31:0] instr, input logic ack, zero, rst,
                              input logic [16:0] exp);
    row_t r;
    r.instr = instr;
    r.ack   = ack;
    r.zero  = zero;
    r.rst   = rst;
    r.exp   = exp;
    return r;
  endfunction

  // Drive one row's inputs and let combinational outputs settle
  task automatic apply(input row_t r);
    Instr   = r.instr;
    MEM_Ack = r.ack;
    Zero    = r.zero;
    Reset   = r.rst;
    #1;
  endtask

  // Pulse reset for one edge and leave the bench in the first FETCH cycle, just after a falling edge
  task automatic do_reset();
    @(negedge Clk);
    Reset   = 1'b0;
    MEM_Ack = 1'b0;
    Zero    = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk(I_BAD, 1, 1, 0, e_quiet(0, 0)));
    rows.push_back(mk(I_BAD, 1, 1, 0, e_quiet(0, 0)));
    rows.push_back(mk(I_SUB, 0, 0, 1, e_fetch()));
    @(negedge Clk);
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  task automatic test_rtype();
    row_t rows[$];
    rows.push_back(mk(I_SUB, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_SUB, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_SUB, 0, 0, 1, e_exec(4'b0001, 0)));
    rows.push_back(mk(I_SUB, 0, 0, 1, e_wb(0)));
    rows.push_back(mk(I_RF7, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_RF7, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_RF7, 0, 0, 1, e_exec(4'b0111, 0)));
    rows.push_back(mk(I_RF7, 0, 0, 1, e_wb(0)));
    rows.push_back(mk(I_RF7, 0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL rtype cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  task automatic test_immediate();
    row_t rows[$];
    rows.push_back(mk(I_ANDI, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_ANDI, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_ANDI, 0, 0, 1, e_exec(4'b0010, 1)));
    rows.push_back(mk(I_ANDI, 0, 0, 1, e_wb(0)));
    rows.push_back(mk(I_ORI,  0, 0, 1, e_fetch()));
    rows.push_back(mk(I_ORI,  0, 0, 1, e_decode()));
    rows.push_back(mk(I_ORI,  0, 0, 1, e_exec(4'b0011, 1)));
    rows.push_back(mk(I_ORI,  0, 0, 1, e_wb(0)));
    rows.push_back(mk(I_LI,   0, 0, 1, e_fetch()));
    rows.push_back(mk(I_LI,   0, 0, 1, e_decode()));
    rows.push_back(mk(I_LI,   0, 0, 1, e_exec(4'b0000, 1)));
    rows.push_back(mk(I_LI,   0, 0, 1, e_wb(0)));
    rows.push_back(mk(I_LI,   0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL immediate cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  // lw with three wait cycles; MEM_Ack pulses outside MEM must be ignored
  task automatic test_lw();
    row_t rows[$];
    rows.push_back(mk(I_LW, 1, 0, 1, e_fetch()));
    rows.push_back(mk(I_LW, 1, 0, 1, e_decode()));
    rows.push_back(mk(I_LW, 1, 0, 1, e_exec(4'b0000, 1)));
    rows.push_back(mk(I_LW, 0, 0, 1, e_mem(0, 0)));
    rows.push_back(mk(I_LW, 0, 0, 1, e_mem(0, 0)));
    rows.push_back(mk(I_LW, 0, 0, 1, e_mem(0, 0)));
    rows.push_back(mk(I_LW, 1, 0, 1, e_mem(0, 0)));
    rows.push_back(mk(I_LW, 0, 0, 1, e_wb(1)));
    rows.push_back(mk(I_LW, 0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL lw cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  // Branches back to back: beq taken/not taken, bne, b
  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(mk(I_BEQ, 0, 1, 1, e_fetch()));
    rows.push_back(mk(I_BEQ, 0, 1, 1, e_decode()));
    rows.push_back(mk(I_BEQ, 0, 1, 1, e_br(1)));
    rows.push_back(mk(I_BEQ, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_BEQ, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_BEQ, 0, 0, 1, e_br(0)));
    rows.push_back(mk(I_BNE, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_BNE, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_BNE, 0, 0, 1, e_br(1)));
    rows.push_back(mk(I_BNE, 0, 1, 1, e_fetch()));
    rows.push_back(mk(I_BNE, 0, 1, 1, e_decode()));
    rows.push_back(mk(I_BNE, 0, 1, 1, e_br(0)));
    rows.push_back(mk(I_B,   0, 0, 1, e_fetch()));
    rows.push_back(mk(I_B,   0, 0, 1, e_decode()));
    rows.push_back(mk(I_B,   0, 0, 1, e_br(1)));
    rows.push_back(mk(I_B,   0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL branch cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  // Illegal opcode reaches ERR on the third cycle and stays there until reset
  task automatic test_illegal();
    row_t rows[$];
    rows.push_back(mk(I_BAD, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_BAD, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_BAD, 0, 0, 1, e_err()));
    rows.push_back(mk(I_BAD, 1, 0, 1, e_err()));
    rows.push_back(mk(I_BAD, 1, 1, 1, e_err()));
    rows.push_back(mk(I_BAD, 0, 0, 0, e_quiet(6, 1)));
    rows.push_back(mk(I_SUB, 0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL illegal cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  // sw never acknowledged: exactly 15 MEM cycles, then ERR with MEM_WrEn dropped
  task automatic test_sw_timeout();
    row_t rows[$];
    rows.push_back(mk(I_SW, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_exec(4'b0000, 1)));
    for (int k = 0; k < 15; k++) rows.push_back(mk(I_SW, 0, 0, 1, e_mem(1, 0)));
    rows.push_back(mk(I_SW, 0, 0, 1, e_err()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_err()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL sw_timeout cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  // Reset and MEM_Ack collide mid-MEM: reset wins, then a clean sw with no wait
  task automatic test_reset_mid_mem();
    row_t rows[$];
    rows.push_back(mk(I_SW, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_exec(4'b0000, 1)));
    rows.push_back(mk(I_SW, 0, 0, 1, e_mem(1, 0)));
    rows.push_back(mk(I_SW, 1, 0, 0, e_quiet(3, 0)));
    rows.push_back(mk(I_SW, 0, 0, 1, e_fetch()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_decode()));
    rows.push_back(mk(I_SW, 0, 0, 1, e_exec(4'b0000, 1)));
    rows.push_back(mk(I_SW, 1, 0, 1, e_mem(1, 1)));
    rows.push_back(mk(I_SW, 0, 0, 1, e_fetch()));
    do_reset();
    for (int c = 0; c < rows.size(); c++) begin
      if (c != 0) @(negedge Clk);
      apply(rows[c]);
      n_checks++;
      if (w_obs !== rows[c].exp) begin
        n_errors++;
        $display("FAIL reset_mid_mem cycle %0d: got %b expected %b", c, w_obs, rows[c].exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rtype();
    test_immediate();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_sw_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum MEM_Ack wait cycles in MEM before entering ERR.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-low reset (0 = reset on the next rising Clk).
REQ-004 SHALL have port Instr, input, 32 bits: instruction register contents from the datapath; opcode is Instr[31:26], func is Instr[3:0].
REQ-005 SHALL have port Zero, input, 1 bit: datapath ALU zero flag.
REQ-006 SHALL have port MEM_Ack, input, 1 bit: data memory completion strobe.
REQ-007 SHALL have port IR_LdEn, output, 1 bit: instruction register load.
REQ-008 SHALL have ports PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel and MEM_WrEn, each output, 1 bit: datapath controls.
REQ-009 SHALL have port ALU_func, output, 4 bits: datapath ALU operation.
REQ-010 SHALL have port MEM_Req, output, 1 bit: data memory access request.
REQ-011 SHALL have port Illegal, output, 1 bit: sticky error flag.
REQ-012 SHALL have port State, output, 3 bits: current state encoding, for debug.

Function
REQ-013 SHALL implement the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5 and ERR=6.
REQ-014 FETCH SHALL assert IR_LdEn for one cycle, then go to DECODE.
REQ-015 DECODE SHALL go to EXEC for opcode 100000 (R-type), 111000 (li), 110000 (addi), 110010 (andi), 110011 (ori), 001111 (lw) and 011111 (sw).
REQ-016 DECODE SHALL go to BRANCH for opcode 111111 (b), 000000 (beq) and 000001 (bne); any other opcode SHALL go to ERR.
REQ-017 EXEC SHALL go to WB for R-type and immediate opcodes, and to MEM for lw and sw.
REQ-018 In EXEC, ALU_func SHALL equal Instr[3:0] for R-type, 0010 for andi, 0011 for ori, and 0000 otherwise; ALU_Bin_sel SHALL be 0 for R-type and 1 otherwise.
REQ-019 In MEM, MEM_Req SHALL be held at 1 until MEM_Ack=1, and MEM_WrEn SHALL be held at 1 throughout MEM for sw only.
REQ-020 On MEM_Ack, lw SHALL go to WB, and sw SHALL assert PC_LdEn=1 and go to FETCH.
REQ-021 MEM SHALL go to ERR if MEM_Ack has not been asserted within MEM_TIMEOUT cycles; the wait counter clears on MEM entry.
REQ-022 WB SHALL assert RF_WrEn=1 and PC_LdEn=1 for one cycle, with RF_WrData_sel=1 for lw and 0 otherwise, then go to FETCH.
REQ-023 BRANCH SHALL drive ALU_func=0001 and RF_B_sel=1, assert PC_LdEn=1, then go to FETCH.
REQ-024 In BRANCH, PC_sel SHALL be 1 for b, Zero for beq, ~Zero for bne; PC_sel SHALL be 0 in all other states.
REQ-025 Instruction latencies SHALL be: R-type/immediate 4 cycles, lw 5+w, sw 4+w (w = MEM_Ack wait cycles), branch 3 cycles.
REQ-026 ERR SHALL set Illegal=1 and hold all enables at 0 until reset.
REQ-027 MEM_Ack outside the MEM state SHALL be ignored.
REQ-028 All outputs SHALL be registered or purely state-decoded, and SHALL be glitch-free with respect to the Instr-only path.

Reset
REQ-029 Reset=0 at a rising Clk SHALL force State=FETCH, Illegal=0 and the wait counter to 0, regardless of the current state, including mid-MEM and ERR.
REQ-030 During reset, all enables (IR_LdEn, PC_LdEn, RF_WrEn, MEM_WrEn, MEM_Req), PC_sel, the select outputs and ALU_func SHALL be 0.
REQ-031 The first FETCH after reset is released SHALL assert IR_LdEn in the cycle following reset release.

Structure
REQ-032 Opcode constants, ALU_func codes and state encodings SHALL reside in the shared package processor_pkg, for use by DATAPATH and the testbench.
REQ-033 The opcode/func-to-control decode SHALL be a combinational sub-module, control_decode, instantiated once.
REQ-034 The wait counter SHALL be $clog2(MEM_TIMEOUT+1) bits wide and SHALL saturate.

Verification
REQ-035 Bench SHALL cover: Instr=0x8000_0001 (sub, R-type) -> states 0,1,2,4; ALU_func=0001 in EXEC; RF_WrEn=1 and PC_LdEn=1 in cycle 4 only.
REQ-036 Bench SHALL cover: lw (opcode 001111) with MEM_Ack after 3 wait cycles -> MEM_Req high for 4 cycles; WB with RF_WrData_sel=1; 8 cycles total.
REQ-037 Bench SHALL cover: beq with Zero=1 and then Zero=0 -> PC_sel=1 and then PC_sel=0 in BRANCH; PC_LdEn=1 both times; 3 cycles each.
REQ-038 Bench SHALL cover: opcode 010101 -> ERR at cycle 3; Illegal=1 and held with all enables 0; after Reset=0 for one Clk -> State=0, Illegal=0.
REQ-039 Bench SHALL cover: sw with MEM_Ack never asserted -> ERR after 15 MEM cycles; MEM_WrEn deasserts on entry to ERR.
REQ-040 Bench SHALL cover: Reset=0 asserted mid-MEM, with MEM_Ack arriving in the same cycle -> reset wins; State=FETCH and no PC_LdEn.
